// File: rtl/cnn_cfg_pkg.sv
// Shared CNN layer configuration types, field widths and scheduler states.
package cnn_cfg_pkg;

  localparam int unsigned ADDR_W     = 22;
  localparam int unsigned IFM_SIZE_W = 9;
  localparam int unsigned IFM_CH_W   = 11;
  localparam int unsigned KSIZE_W    = 2;
  localparam int unsigned NFILT_W    = 11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_I,
    COMPUTE,
    WRITE,
    NEXT,
    DONE
  } sched_state_e;

  typedef struct packed {
    logic [IFM_SIZE_W-1:0] ifm_size;
    logic [IFM_CH_W-1:0]   ifm_channel;
    logic [KSIZE_W-1:0]    kernel_size;
    logic [NFILT_W-1:0]    num_filter;
    logic [ADDR_W-1:0]     start_read_addr;
    logic [ADDR_W-1:0]     start_write_addr;
  } layer_cfg_t;

  // Output feature map edge length for a valid (non-degenerate) config.
  function automatic logic [IFM_SIZE_W-1:0] calc_ofm_size(
    input logic [IFM_SIZE_W-1:0] ifm,
    input logic [KSIZE_W-1:0]    k
  );
    return ifm - IFM_SIZE_W'(k) + IFM_SIZE_W'(1);
  endfunction

  // True when the layer has no work: no filters or kernel larger than the IFM.
  function automatic logic cfg_degenerate(input layer_cfg_t c);
    return (c.num_filter == '0) || (c.ifm_size < IFM_SIZE_W'(c.kernel_size));
  endfunction

endpackage

// File: rtl/req_ack_port.sv
// Request holding register: req rises on set and stays up until acknowledged.
module req_ack_port (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic ack,
  output logic req,
  output logic xfer
);

  logic req_q, req_d;

  // Raise on set, drop after the edge where req and ack are both high.
  always_comb begin
    req_d = req_q;
    if (set) begin
      req_d = 1'b1;
    end else if (req_q && ack) begin
      req_d = 1'b0;
    end
  end

  // Request register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  assign req  = req_q;
  assign xfer = req_q & ack;

endmodule

// File: rtl/layer_tile_scheduler.sv
// Walks filter groups and output rows of one conv layer, driving the
// weight/IFM/array/writeback handshakes with incrementally built addresses.
module layer_tile_scheduler
  import cnn_cfg_pkg::*;
#(
  parameter int unsigned SYS_ROWS = 16,
  parameter int unsigned ADDR_W   = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_layer,
  input  logic [8:0]        ifm_size,
  input  logic [10:0]       ifm_channel,
  input  logic [1:0]        kernel_size,
  input  logic [10:0]       num_filter,
  input  logic [ADDR_W-1:0] start_read_addr,
  input  logic [ADDR_W-1:0] start_write_addr,
  output logic              wgt_req,
  input  logic              wgt_ack,
  output logic              ifm_req,
  input  logic              ifm_ack,
  output logic              comp_start,
  input  logic              comp_done,
  output logic              wb_req,
  input  logic              wb_ack,
  output logic [6:0]        grp_idx,
  output logic [4:0]        grp_filt,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              busy,
  output logic              done_layer
);

  localparam int unsigned GRP_SHIFT = $clog2(SYS_ROWS);

  sched_state_e      state_q, state_d;
  layer_cfg_t        cfg_q, cfg_d, cfg_in;
  logic [6:0]        grp_q, grp_d;
  logic [8:0]        row_q, row_d;
  logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [ADDR_W-1:0] grp_base_q, grp_base_d;
  logic [ADDR_W-1:0] mcand_q, mcand_d;
  logic [ADDR_W-1:0] prod_q, prod_d;
  logic [8:0]        mplier_q, mplier_d;
  logic              comp_start_q, comp_start_d;
  logic              done_q, done_d;

  logic [8:0]        ofm_size, in_ofm;
  logic [10:0]       nf_m1;
  logic [6:0]        last_grp;
  logic [4:0]        last_filt;
  logic              wgt_set, ifm_set, wb_set;
  logic              wgt_xfer, ifm_xfer, wb_xfer;

  assign cfg_in = '{ifm_size:         ifm_size,
                    ifm_channel:      ifm_channel,
                    kernel_size:      kernel_size,
                    num_filter:       num_filter,
                    start_read_addr:  start_read_addr,
                    start_write_addr: start_write_addr};

  assign in_ofm    = calc_ofm_size(ifm_size, kernel_size);
  assign ofm_size  = calc_ofm_size(cfg_q.ifm_size, cfg_q.kernel_size);
  assign nf_m1     = cfg_q.num_filter - 11'd1;
  assign last_grp  = 7'(nf_m1 >> GRP_SHIFT);
  assign last_filt = 5'(nf_m1 & 11'(SYS_ROWS - 1)) + 5'd1;

  // Next-state, counters, address accumulators and the group-stride product.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    grp_d        = grp_q;
    row_d        = row_q;
    ifm_addr_d   = ifm_addr_q;
    wb_addr_d    = wb_addr_q;
    grp_base_d   = grp_base_q;
    mcand_d      = mcand_q;
    prod_d       = prod_q;
    mplier_d     = mplier_q;
    comp_start_d = 1'b0;
    done_d       = (state_q == DONE);

    // Shift-add SYS_ROWS*ofm^2, one multiplier bit per cycle from LOAD_W of
    // group 0. It needs bitlength(ofm) cycles, always fewer than group 0 lasts.
    if (mplier_q != '0) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_layer) begin
          cfg_d      = cfg_in;
          grp_d      = '0;
          row_d      = '0;
          ifm_addr_d = start_read_addr;
          wb_addr_d  = start_write_addr;
          grp_base_d = start_write_addr;
          prod_d     = '0;
          mcand_d    = ADDR_W'(in_ofm) << GRP_SHIFT;
          if (cfg_degenerate(cfg_in)) begin
            mplier_d = '0;
            state_d  = DONE;
          end else begin
            mplier_d = in_ofm;
            state_d  = LOAD_W;
          end
        end
      end
      LOAD_W:  if (wgt_xfer)  state_d = LOAD_I;
      LOAD_I: begin
        if (ifm_xfer) begin
          comp_start_d = 1'b1;
          state_d      = COMPUTE;
        end
      end
      COMPUTE: if (comp_done) state_d = WRITE;
      WRITE:   if (wb_xfer)   state_d = NEXT;
      NEXT: begin
        if (row_q < ofm_size - 9'd1) begin
          row_d      = row_q + 9'd1;
          ifm_addr_d = ifm_addr_q + ADDR_W'(cfg_q.ifm_size);
          wb_addr_d  = wb_addr_q + ADDR_W'(ofm_size);
          state_d    = LOAD_I;
        end else if (grp_q < last_grp) begin
          row_d      = '0;
          grp_d      = grp_q + 7'd1;
          ifm_addr_d = cfg_q.start_read_addr;
          grp_base_d = grp_base_q + prod_q;
          wb_addr_d  = grp_base_q + prod_q;
          state_d    = LOAD_W;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, configuration and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      grp_q        <= '0;
      row_q        <= '0;
      ifm_addr_q   <= '0;
      wb_addr_q    <= '0;
      grp_base_q   <= '0;
      mcand_q      <= '0;
      prod_q       <= '0;
      mplier_q     <= '0;
      comp_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      grp_q        <= grp_d;
      row_q        <= row_d;
      ifm_addr_q   <= ifm_addr_d;
      wb_addr_q    <= wb_addr_d;
      grp_base_q   <= grp_base_d;
      mcand_q      <= mcand_d;
      prod_q       <= prod_d;
      mplier_q     <= mplier_d;
      comp_start_q <= comp_start_d;
      done_q       <= done_d;
    end
  end

  assign wgt_set = (state_d == LOAD_W) && (state_q != LOAD_W);
  assign ifm_set = (state_d == LOAD_I) && (state_q != LOAD_I);
  assign wb_set  = (state_d == WRITE)  && (state_q != WRITE);

  req_ack_port u_wgt_port (
    .clk  (clk),
    .rst_n(rst_n),
    .set  (wgt_set),
    .ack  (wgt_ack),
    .req  (wgt_req),
    .xfer (wgt_xfer)
  );

  req_ack_port u_ifm_port (
    .clk  (clk),
    .rst_n(rst_n),
    .set  (ifm_set),
    .ack  (ifm_ack),
    .req  (ifm_req),
    .xfer (ifm_xfer)
  );

  req_ack_port u_wb_port (
    .clk  (clk),
    .rst_n(rst_n),
    .set  (wb_set),
    .ack  (wb_ack),
    .req  (wb_req),
    .xfer (wb_xfer)
  );

  assign comp_start = comp_start_q;
  assign done_layer = done_q;
  assign busy       = (state_q != IDLE) || done_q;
  assign grp_idx    = grp_q;
  assign ifm_addr   = ifm_addr_q;
  assign wb_addr    = wb_addr_q;
  assign grp_filt   = (state_q inside {LOAD_W, LOAD_I, COMPUTE, WRITE, NEXT})
                    ? ((grp_q == last_grp) ? last_filt : 5'(SYS_ROWS))
                    : '0;

endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Directed bench for layer_tile_scheduler: table of layer configs with
// hand-computed results, plus stray-input and mid-layer reset sequences.
module tb_layer_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_layer = 1'b0;
  logic [8:0]  ifm_size = '0;
  logic [10:0] ifm_channel = '0;
  logic [1:0]  kernel_size = '0;
  logic [10:0] num_filter = '0;
  logic [21:0] start_read_addr = '0;
  logic [21:0] start_write_addr = '0;
  logic        wgt_req, ifm_req, comp_start, wb_req, busy, done_layer;
  logic        wgt_ack, ifm_ack, comp_done, wb_ack;
  logic [6:0]  grp_idx;
  logic [4:0]  grp_filt;
  logic [21:0] ifm_addr, wb_addr;

  // auto responder vs. manually driven handshake inputs
  bit   auto_en = 1'b1;
  int   max_delay = 0;
  logic a_wgt = 0, a_ifm = 0, a_comp = 0, a_wb = 0;
  logic m_wgt = 0, m_ifm = 0, m_comp = 0, m_wb = 0;
  assign wgt_ack   = auto_en ? a_wgt  : m_wgt;
  assign ifm_ack   = auto_en ? a_ifm  : m_ifm;
  assign comp_done = auto_en ? a_comp : m_comp;
  assign wb_ack    = auto_en ? a_wb   : m_wb;

  layer_tile_scheduler #(.SYS_ROWS(16), .ADDR_W(22)) dut (
    .clk(clk), .rst_n(rst_n), .start_layer(start_layer),
    .ifm_size(ifm_size), .ifm_channel(ifm_channel), .kernel_size(kernel_size),
    .num_filter(num_filter), .start_read_addr(start_read_addr),
    .start_write_addr(start_write_addr),
    .wgt_req(wgt_req), .wgt_ack(wgt_ack), .ifm_req(ifm_req), .ifm_ack(ifm_ack),
    .comp_start(comp_start), .comp_done(comp_done), .wb_req(wb_req), .wb_ack(wb_ack),
    .grp_idx(grp_idx), .grp_filt(grp_filt), .ifm_addr(ifm_addr), .wb_addr(wb_addr),
    .busy(busy), .done_layer(done_layer)
  );

  always #5 clk = ~clk;

  function automatic int dly();
    return (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
  endfunction

  // responder: acks after a delay, comp_done at least one cycle after comp_start
  int  cw = 0, ci = 0, cb = 0, cc = 0;
  bit  pend = 0;
  always @(negedge clk) begin
    if (!rst_n || !auto_en) begin
      a_wgt = 0; a_ifm = 0; a_wb = 0; a_comp = 0; pend = 0;
      cw = dly(); ci = dly(); cb = dly();
    end else begin
      if (a_wgt) begin a_wgt = 0; cw = dly(); end
      else if (wgt_req) begin if (cw == 0) a_wgt = 1; else cw--; end
      if (a_ifm) begin a_ifm = 0; ci = dly(); end
      else if (ifm_req) begin if (ci == 0) a_ifm = 1; else ci--; end
      if (a_wb) begin a_wb = 0; cb = dly(); end
      else if (wb_req) begin if (cb == 0) a_wb = 1; else cb--; end
      if (a_comp) a_comp = 0;
      else if (pend) begin if (cc == 0) begin a_comp = 1; pend = 0; end else cc--; end
      if (comp_start) begin pend = 1; cc = dly(); end
    end
  end

  // monitor
  bit          clr = 0;
  int          mon_comp, mon_done, mon_wgt, mon_err;
  logic [4:0]  mon_first_filt, mon_last_filt;
  logic [21:0] mon_last_ifm, mon_last_wb;
  logic [21:0] wb_log[$], ref_log[$];
  logic        pw = 0, pwx = 0, pi = 0, pix = 0, pb = 0, pbx = 0, pc = 0;
  always @(negedge clk) begin
    #2;
    if (clr) begin
      mon_comp = 0; mon_done = 0; mon_wgt = 0; mon_err = 0;
      mon_first_filt = '0; mon_last_filt = '0; mon_last_ifm = '0; mon_last_wb = '0;
      wb_log.delete();
    end else if (rst_n) begin
      if (comp_start) mon_comp++;
      if (comp_start && pc) mon_err++;
      if (done_layer) mon_done++;
      if (wgt_req && wgt_ack) begin
        if (int'(grp_idx) != mon_wgt) mon_err++;
        if (mon_wgt == 0) mon_first_filt = grp_filt;
        mon_last_filt = grp_filt;
        mon_wgt++;
      end
      if (ifm_req && ifm_ack) mon_last_ifm = ifm_addr;
      if (wb_req && wb_ack) begin wb_log.push_back(wb_addr); mon_last_wb = wb_addr; end
      if ((pw && !pwx && !wgt_req) || (pi && !pix && !ifm_req) || (pb && !pbx && !wb_req))
        mon_err++;
    end
    if (rst_n) begin
      pw = wgt_req; pwx = wgt_req && wgt_ack;
      pi = ifm_req; pix = ifm_req && ifm_ack;
      pb = wb_req;  pbx = wb_req && wb_ack;
      pc = comp_start;
    end else begin
      pw = 0; pwx = 0; pi = 0; pix = 0; pb = 0; pbx = 0; pc = 0;
    end
  end

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0]  ifm;
    logic [1:0]  k;
    logic [10:0] nf;
    logic [21:0] rd, wr;
    int          lat, comps, grps, first_filt, last_filt;
    logic [21:0] last_ifm, last_wb;
  } vec_t;
  vec_t vecs[7];

  task automatic mon_clear();
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
  endtask

  task automatic drive_cfg(input vec_t v);
    ifm_size = v.ifm; kernel_size = v.k; num_filter = v.nf;
    start_read_addr = v.rd; start_write_addr = v.wr; ifm_channel = 11'd64;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start_layer = 0;
      if (done_layer) begin lat = c; break; end
    end
  endtask

  task automatic run_layer(input vec_t v, input int budget, output int lat,
                           output logic b_done, output logic b_after);
    @(negedge clk);
    drive_cfg(v);
    start_layer = 1;
    wait_done(budget, lat);
    b_done = busy;
    @(negedge clk);
    b_after = busy;
    @(negedge clk);
  endtask

  initial begin
    int   lat, mism;
    logic bd, ba;

    //            ifm    k     nf       rd           wr        lat  comp grp ff lf  last_ifm     last_wb
    vecs[0] = '{9'd6,  2'd1, 11'd256, 22'h000100, 22'h3FF000, 498,  96, 16, 16, 16, 22'h00011E, 22'h0011DE};
    vecs[1] = '{9'd13, 2'd1, 11'd255, 22'h000000, 22'h000000, 1058, 208, 16, 16, 15, 22'd156,    22'd40716};
    vecs[2] = '{9'd5,  2'd3, 11'd20,  22'h001000, 22'h002000, 34,   6,   2, 16, 4,  22'd4106,   22'd8342};
    vecs[3] = '{9'd3,  2'd3, 11'd1,   22'd7,      22'd9,      8,    1,   1, 1,  1,  22'd7,      22'd9};
    vecs[4] = '{9'd2,  2'd3, 11'd16,  22'h000010, 22'h000020, 2,    0,   0, 0,  0,  22'd0,      22'd0};
    vecs[5] = '{9'd8,  2'd1, 11'd0,   22'h000010, 22'h000020, 2,    0,   0, 0,  0,  22'd0,      22'd0};
    vecs[6] = '{9'd9,  2'd3, 11'd17,  22'h3FFFF0, 22'h000000, 74,   14,  2, 16, 1,  22'h000026, 22'd826};

    repeat (3) @(negedge clk);
    check("reset_outputs", {wgt_req, ifm_req, comp_start, wb_req, busy, done_layer,
                            grp_idx, grp_filt, ifm_addr, wb_addr}, 64'd0);
    rst_n = 1;
    @(negedge clk);
    check("post_reset_idle", {busy, wgt_req, grp_filt}, 64'd0);

    // zero-wait table
    for (int i = 0; i < 7; i++) begin
      mon_clear();
      run_layer(vecs[i], 3000, lat, bd, ba);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_comp_starts", i), mon_comp, vecs[i].comps);
      check($sformatf("v%0d_wb_count", i), wb_log.size(), vecs[i].comps);
      check($sformatf("v%0d_done_pulses", i), mon_done, 1);
      check($sformatf("v%0d_groups", i), mon_wgt, vecs[i].grps);
      check($sformatf("v%0d_first_filt", i), mon_first_filt, vecs[i].first_filt);
      check($sformatf("v%0d_last_filt", i), mon_last_filt, vecs[i].last_filt);
      check($sformatf("v%0d_last_ifm_addr", i), mon_last_ifm, vecs[i].last_ifm);
      check($sformatf("v%0d_last_wb_addr", i), mon_last_wb, vecs[i].last_wb);
      check($sformatf("v%0d_protocol_errs", i), mon_err, 0);
      check($sformatf("v%0d_busy_at_done", i), bd, 1);
      check($sformatf("v%0d_busy_after", i), ba, 0);
      if (i == 0) ref_log = wb_log;
    end

    // random ack delays must reproduce the zero-wait address sequence
    max_delay = 7;
    mon_clear();
    run_layer(vecs[0], 20000, lat, bd, ba);
    check("rnd_done", lat > 0, 1);
    check("rnd_comp_starts", mon_comp, 96);
    check("rnd_done_pulses", mon_done, 1);
    check("rnd_protocol_errs", mon_err, 0);
    mism = (wb_log.size() == ref_log.size()) ? 0 : 1000;
    foreach (ref_log[j]) if (j < wb_log.size() && wb_log[j] != ref_log[j]) mism++;
    check("rnd_wb_sequence", mism, 0);
    max_delay = 0;

    // stray start/acks must not disturb a running layer
    mon_clear();
    auto_en = 0;
    @(negedge clk);
    drive_cfg(vecs[2]);
    start_layer = 1;
    @(negedge clk);
    start_layer = 0;
    check("stray_wgt_req_up", wgt_req, 1);
    start_layer = 1; ifm_size = 9'd9; num_filter = 11'd200;
    m_comp = 1; m_ifm = 1; m_wb = 1;
    @(negedge clk);
    start_layer = 0; m_comp = 0; m_ifm = 0; m_wb = 0;
    check("stray_in_load_w", {wgt_req, ifm_req, wb_req, comp_start, busy, grp_idx}, 64'h1_0_8 >> 0 == 0 ? 0 : {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0});
    m_wgt = 1;
    @(negedge clk);
    m_wgt = 0;
    check("stray_ifm_req_up", {ifm_req, ifm_addr}, {1'b1, 22'h001000});
    m_wgt = 1; m_comp = 1; m_wb = 1;
    @(negedge clk);
    m_wgt = 0; m_comp = 0; m_wb = 0;
    check("stray_in_load_i", {ifm_req, comp_start, wgt_req, wb_req, ifm_addr, grp_filt},
          {1'b1, 1'b0, 1'b0, 1'b0, 22'h001000, 5'd16});
    auto_en = 1;
    wait_done(500, lat);
    @(negedge clk);
    check("stray_finished", lat > 0, 1);
    check("stray_comp_starts", mon_comp, 6);
    check("stray_done_pulses", mon_done, 1);
    check("stray_last_wb_addr", mon_last_wb, 22'd8342);
    check("stray_last_filt", mon_last_filt, 5'd4);

    // reset during COMPUTE
    mon_clear();
    @(negedge clk);
    drive_cfg(vecs[0]);
    start_layer = 1;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start_layer = 0;
      if (comp_start) begin lat = c; break; end
    end
    check("rst_reached_compute", lat > 0, 1);
    #1 rst_n = 0;
    #1 check("rst_async_outputs", {wgt_req, ifm_req, comp_start, wb_req, busy, done_layer}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    check("rst_idle_after", {busy, wgt_req, ifm_req, wb_req}, 64'd0);
    check("rst_no_done", mon_done, 0);
    mon_clear();
    run_layer(vecs[3], 200, lat, bd, ba);
    check("rst_fresh_latency", lat, 8);
    check("rst_fresh_comp_starts", mon_comp, 1);
    check("rst_fresh_last_wb", mon_last_wb, 22'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_tile_scheduler.md
# layer_tile_scheduler

Sequences one convolution layer on the systolic array. It latches the per-layer configuration on `start_layer` and walks filter groups (outer loop) and output rows (inner loop). For each step it issues request/acknowledge handshakes to the weight loader, IFM loader, array and OFM writer, with base addresses computed for each. It sits between the layer-level main controller and the datapath, and pulses `done_layer` back when the last row of the last filter group is written.

## Interface
- `SYS_ROWS`, 16: filters processed per array pass (one filter group).
- `ADDR_W`, 22: OFM/IFM RAM address width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_layer` in 1: one-cycle start; config inputs are valid in the same cycle.
- `ifm_size` in 9: IFM width/height.
- `ifm_channel` in 11: IFM channels.
- `kernel_size` in 2: 1 or 3.
- `num_filter` in 11: filter count.
- `start_read_addr` in ADDR_W: IFM base address.
- `start_write_addr` in ADDR_W: OFM base address.
- `wgt_req` out 1, `wgt_ack` in 1: load weights for group `grp_idx`.
- `ifm_req` out 1, `ifm_ack` in 1: load `kernel_size` IFM rows from `ifm_addr`.
- `comp_start` out 1, `comp_done` in 1: array pass trigger and completion pulse.
- `wb_req` out 1, `wb_ack` in 1: write one OFM row per filter to `wb_addr`.
- `grp_idx` out 7: current filter group.
- `grp_filt` out 5: valid filters in the current group (1..SYS_ROWS).
- `ifm_addr` out ADDR_W: `start_read_addr + row*ifm_size`.
- `wb_addr` out ADDR_W: `start_write_addr + grp_idx*SYS_ROWS*ofm_size² + row*ofm_size`.
- `busy` out 1: high from the cycle after accepted `start_layer` through the `done_layer` cycle.
- `done_layer` out 1: one-cycle pulse.

## Operation
- States: IDLE, LOAD_W, LOAD_I, COMPUTE, WRITE, NEXT, DONE.
- IDLE:
  - Latch config on `start_layer`.
  - Compute `ofm_size = ifm_size - kernel_size + 1` and `n_grp = ceil(num_filter/SYS_ROWS)`.
  - Go to LOAD_W. If `num_filter==0` or `ifm_size<kernel_size`, go to DONE instead.
- LOAD_W: assert `wgt_req` until `wgt_ack`, then go to LOAD_I.
- LOAD_I: assert `ifm_req` until `ifm_ack`, then go to COMPUTE.
- COMPUTE: pulse `comp_start` on the first cycle only; wait for `comp_done`, then go to WRITE.
- WRITE: assert `wb_req` until `wb_ack`, then go to NEXT.
- NEXT:
  - If `row<ofm_size-1`: increment row, go to LOAD_I.
  - Else if `grp_idx<n_grp-1`: row←0, increment `grp_idx`, go to LOAD_W.
  - Else go to DONE.
- DONE: `done_layer`=1 for one cycle, then go to IDLE.
- `grp_filt` is SYS_ROWS except in the last group, where it is `num_filter - grp_idx*SYS_ROWS`. Example: 255 → last group has 15.
- Address arithmetic:
  - Addresses use incremental accumulators only; no runtime multiplier.
  - `ifm_addr` adds `ifm_size` per row and resets on each group.
  - `wb_addr` adds `ofm_size` per row. The group base adds `SYS_ROWS*ofm_size²`, precomputed during LOAD_W of group 0 with one multi-cycle or constant-shift product.
  - All sums are modulo 2^ADDR_W; there is no overflow check.
- `start_layer` outside IDLE is ignored.
- Acks arriving while the matching request is low are ignored. A `comp_done` outside COMPUTE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; counters and config registers 0.
- Handshake:
  - A transfer completes on a rising edge where req=1 and ack=1.
  - req is low in the next cycle.
  - ack may arrive in the same cycle req rises (zero wait).
- Cycle costs:
  - `start_layer` → `wgt_req` high: 1 cycle.
  - ack → next req high: 1 cycle within a row. The path through NEXT adds 1 cycle.
- Minimum per row with zero-wait acks and `comp_done` one cycle after `comp_start`: 5 cycles (LOAD_I, COMPUTE×2, WRITE, NEXT).
- Degenerate config: `done_layer` 2 cycles after `start_layer`.
- Reset mid-operation: all requests drop immediately (asynchronous), state goes to IDLE, and no `done_layer` is produced.

## Structure
- Shared package `cnn_cfg_pkg`:
  - State enum.
  - `ADDR_W`.
  - Config field widths (9/11/2/11).
  - Layer config struct, reusable by the main controller.
- Optional sub-module `req_ack_port`: a req/ack holding register, instantiated three times for the weight, IFM and writeback ports.

## Test plan
- Config 6/1024/k1/256 filters, SYS_ROWS=16, zero-wait acks → exactly 96 `comp_start` pulses, `grp_idx` 0..15, one `done_layer`, last `wb_addr = base+15*16*36+5*6`.
- 255 filters, ifm 13, k1 → groups 0..15, `grp_filt`=16 for groups 0..14 and 15 in group 15.
- Random ack delays of 0..7 cycles → request held until ack, same address sequence as the zero-wait run, no duplicate or missed pulses.
- `start_layer` pulsed mid-layer, and stray `wgt_ack`/`comp_done` injected → no state or counter change.
- `rst_n` low during COMPUTE → all requests 0 in the same cycle, IDLE afterwards, a fresh `start_layer` runs cleanly.
- `ifm_size=2`, k3 → `done_layer` 2 cycles after start, no requests asserted.
